spi_poller: RTL and testbench

Parametrised SPI master that continuously polls one or more SPI peripherals (e.g. Pmod joysticks) over fixed-length full-duplex frames and presents each received frame with a one-cycle valid strobe. It replaces the fixed 40-bit, single-device, free-running-trigger arrangement: frame width, SCK rate, chip-select timing, inter-frame gap, device count and clock polarity are all parameters. It sits between the board SPI pins and consumers such as the paddle logic and `display4digit`.

---
 rtl/spi_poller.sv | 150 +++++++++++++++
 tb/tb_spi_poller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_poller.sv
// Round-robin SPI master (CPHA=0): fixed-length full-duplex frames to NUM_CH devices,
// each received frame presented on rx_frame/rx_ch with a one-cycle rx_valid strobe.
module spi_poller #(
  parameter int FRAME_BITS = 40,
  parameter int NUM_CH     = 2,
  parameter int HALF_DIV   = 25,
  parameter int CS_SETUP   = 25,
  parameter int GAP        = 50000,
  parameter bit CPOL       = 1'b0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk50M,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUM_CH*FRAME_BITS-1:0] tx_frame,
  output logic [NUM_CH-1:0]            cs_n,
  output logic                         sck,
  output logic                         mosi,
  input  logic                         miso,
  output logic [FRAME_BITS-1:0]        rx_frame,
  output logic [CH_W-1:0]              rx_ch,
  output logic                         rx_valid,
  output logic                         busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int CNT_MAX0 = (CS_SETUP > HALF_DIV) ? CS_SETUP : HALF_DIV;
  localparam int CNT_MAX  = (GAP > CNT_MAX0) ? GAP : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int BIT_W    = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  phase;
  logic [CH_W-1:0]       ch;
  logic [FRAME_BITS-1:0] tx_sh;
  logic [FRAME_BITS-1:0] rx_sh;
  logic [FRAME_BITS-1:0] tx_sel;
  logic                  start;

  always_comb begin
    tx_sel = tx_frame[FRAME_BITS-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == CH_W'(c)) tx_sel = tx_frame[c*FRAME_BITS +: FRAME_BITS];
    end
  end

  // A new frame starts from IDLE or at the end of the gap, only while enabled.
  assign start = enable && ((state == S_IDLE) || ((state == S_GAP) && (cnt == GAP_LAST)));

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      phase    <= 1'b0;
      ch       <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cs_n     <= '1;
      sck      <= CPOL;
      mosi     <= 1'b0;
      rx_frame <= '0;
      rx_ch    <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: ;
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state   <= S_XFER;
            cnt     <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (cnt != HALF_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!phase) begin
              sck   <= ~CPOL;
              rx_sh <= {rx_sh[FRAME_BITS-2:0], miso};
              phase <= 1'b1;
            end else begin
              sck   <= CPOL;
              phase <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= S_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx_sh   <= {tx_sh[FRAME_BITS-2:0], 1'b0};
                mosi    <= tx_sh[FRAME_BITS-2];
              end
            end
          end
        end
        S_HOLD: begin
          if (cnt == HALF_LAST) begin
            state    <= S_GAP;
            cnt      <= '0;
            cs_n     <= '1;
            rx_frame <= rx_sh;
            rx_ch    <= ch;
            rx_valid <= 1'b1;
            ch       <= (ch == CH_LAST) ? '0 : ch + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (start) begin
        state <= S_SETUP;
        cnt   <= '0;
        busy  <= 1'b1;
        cs_n  <= ~(NUM_CH'(1) << ch);
        tx_sh <= tx_sel;
        mosi  <= tx_sel[FRAME_BITS-1];
      end
    end
  end

endmodule

// File: tb/tb_spi_poller.sv
// Directed bench for spi_poller: slave models, frame scoreboard, timing and boundary checks.
module tb_spi_poller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 40-bit frames, two channels, CPOL=0
  logic        rst, enable;
  logic        miso = 1'b0;
  logic [79:0] tx_frame;
  logic [1:0]  cs_n;
  logic        sck, mosi, rx_valid, busy;
  logic [39:0] rx_frame;
  logic [0:0]  rx_ch;

  spi_poller #(.FRAME_BITS(40), .NUM_CH(2), .HALF_DIV(2), .CS_SETUP(3), .GAP(4), .CPOL(1'b0)) dut (
    .clk50M(clk), .rst(rst), .enable(enable), .tx_frame(tx_frame), .cs_n(cs_n), .sck(sck),
    .mosi(mosi), .miso(miso), .rx_frame(rx_frame), .rx_ch(rx_ch), .rx_valid(rx_valid), .busy(busy));

  // Second instance: 8-bit frames, one channel, CPOL=1
  logic       rst1, en1;
  logic       miso1 = 1'b0;
  logic [7:0] tx1, rxf1;
  logic [0:0] cs1, rxch1;
  logic       sck1, mosi1, rv1, busy1;

  spi_poller #(.FRAME_BITS(8), .NUM_CH(1), .HALF_DIV(2), .CS_SETUP(3), .GAP(4), .CPOL(1'b1)) dut1 (
    .clk50M(clk), .rst(rst1), .enable(en1), .tx_frame(tx1), .cs_n(cs1), .sck(sck1),
    .mosi(mosi1), .miso(miso1), .rx_frame(rxf1), .rx_ch(rxch1), .rx_valid(rv1), .busy(busy1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave models and monitor for the main instance
  logic [39:0] reply [2];
  logic [39:0] shr [2];
  logic [39:0] cap [2];
  logic [39:0] last_cap [2];
  int          low_cnt [2];
  int          low_len [2];
  int          rises [2];
  int          falls [2];
  logic [1:0]  prev_cs = 2'b11;
  logic        prev_sck = 1'b0;
  logic        prev_rv = 1'b0;
  int cyc = 0, rv_count = 0, frames = 0, stray = 0, both_low = 0, wide_rv = 0;
  int last_rv_cyc = 0, last_period = 0;
  logic [39:0] exp_d [$];
  logic        exp_c [$];

  always @(negedge clk) begin
    cyc++;
    if (cs_n == 2'b00) both_low++;
    if (sck !== prev_sck && prev_cs == 2'b11 && cs_n == 2'b11) stray++;
    for (int c = 0; c < 2; c++) begin
      if (prev_cs[c] && !cs_n[c]) begin
        frames++;
        low_cnt[c] = 0; rises[c] = 0; falls[c] = 0;
        shr[c] = reply[c]; cap[c] = '0;
        exp_d.push_back(reply[c]);
        exp_c.push_back(1'(c));
      end
      if (!cs_n[c]) begin
        low_cnt[c]++;
        if (sck && !prev_sck) begin rises[c]++; cap[c] = {cap[c][38:0], mosi}; end
        if (!sck && prev_sck) begin falls[c]++; shr[c] = shr[c] << 1; end
      end
      if (!prev_cs[c] && cs_n[c]) begin low_len[c] = low_cnt[c]; last_cap[c] = cap[c]; end
    end
    if (rx_valid) begin
      rv_count++;
      if (prev_rv) wide_rv++;
      last_period = cyc - last_rv_cyc;
      last_rv_cyc = cyc;
      chk("rv_at_cs_rise", 64'((prev_cs != 2'b11) && (cs_n == 2'b11)), 64'(1));
      chk("rx_expected", 64'(exp_d.size() > 0), 64'(1));
      if (exp_d.size() > 0) begin
        chk("sb_rx_frame", 64'(rx_frame), 64'(exp_d.pop_front()));
        chk("sb_rx_ch", 64'(rx_ch), 64'(exp_c.pop_front()));
      end
    end
    miso = !cs_n[0] ? shr[0][39] : (!cs_n[1] ? shr[1][39] : 1'b0);
    prev_rv = rx_valid; prev_cs = cs_n; prev_sck = sck;
  end

  // Slave model for the CPOL=1 instance
  logic [7:0] reply1, shr1, cap1, last_cap1;
  logic       prev_cs1 = 1'b1, prev_sck1 = 1'b1, first_fall1 = 1'b0;
  int low1 = 0, low_len1 = 0, lead1 = 0, trail1 = 0, rv1_count = 0, stray1 = 0;

  always @(negedge clk) begin
    if (sck1 !== prev_sck1 && prev_cs1 && cs1[0]) stray1++;
    if (prev_cs1 && !cs1[0]) begin
      shr1 = reply1; cap1 = '0; low1 = 0; lead1 = 0; trail1 = 0; first_fall1 = 1'b0;
    end
    if (!cs1[0]) begin
      low1++;
      if (prev_sck1 && !sck1) begin
        if (lead1 == 0 && trail1 == 0) first_fall1 = 1'b1;
        lead1++;
        cap1 = {cap1[6:0], mosi1};
      end
      if (!prev_sck1 && sck1) begin trail1++; shr1 = shr1 << 1; end
    end
    if (!prev_cs1 && cs1[0]) begin low_len1 = low1; last_cap1 = cap1; end
    if (rv1) rv1_count++;
    miso1 = !cs1[0] ? shr1[7] : 1'b0;
    prev_cs1 = cs1[0]; prev_sck1 = sck1;
  end

  task automatic wait_rv(input int target, input int budget);
    int n = 0;
    while (rv_count < target && n < budget) begin @(negedge clk); n++; end
    if (rv_count < target) chk("rv_timeout", 64'(rv_count), 64'(target));
  endtask

  task automatic wait_cs_fall(input int budget);
    int n = 0;
    while (cs_n == 2'b11 && n < budget) begin @(negedge clk); n++; end
    if (cs_n == 2'b11) chk("cs_fall_timeout", 64'(cs_n), 64'(0));
  endtask

  initial begin
    int rv0, f0, n;
    rst = 1'b1; enable = 1'b0; rst1 = 1'b1; en1 = 1'b0;
    tx1 = 8'hC5; reply1 = 8'h3C;
    tx_frame = {40'h00_0000_0000, 40'h83_0000_0000};
    reply[0] = 40'h12_3456_789A; reply[1] = 40'h00_0000_0000;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_cs_n", 64'(cs_n), 64'(2'b11));
    chk("rst_sck", 64'(sck), 64'(0));
    chk("rst_mosi", 64'(mosi), 64'(0));
    chk("rst_rx_frame", 64'(rx_frame), 64'(0));
    chk("rst_rx_ch", 64'(rx_ch), 64'(0));
    chk("rst_rx_valid", 64'(rx_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst1_sck", 64'(sck1), 64'(1));
    chk("rst1_cs_n", 64'(cs1), 64'(1));
    chk("rst1_busy", 64'(busy1), 64'(0));

    // Single frame on channel 0
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("start_cs_n", 64'(cs_n), 64'(2'b10));
    chk("start_busy", 64'(busy), 64'(1));
    enable = 1'b0;
    wait_rv(1, 400);
    chk("t1_slave_rx", 64'(last_cap[0]), 64'(40'h83_0000_0000));
    chk("t1_cs_low_len", 64'(low_len[0]), 64'(165));
    chk("t1_sck_rises", 64'(rises[0]), 64'(40));
    chk("t1_sck_falls", 64'(falls[0]), 64'(40));
    chk("t1_rx_frame", 64'(rx_frame), 64'(40'h12_3456_789A));
    chk("t1_rx_ch", 64'(rx_ch), 64'(0));
    @(negedge clk);
    chk("t1_rv_one_cycle", 64'(rx_valid), 64'(0));
    repeat (6) @(negedge clk);
    chk("t1_idle_busy", 64'(busy), 64'(0));
    chk("t1_idle_cs_n", 64'(cs_n), 64'(2'b11));

    // Round robin from channel 0 with enable held high
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_d.delete(); exp_c.delete();
    reply[0] = 40'hAA_AAAA_AAAA; reply[1] = 40'h55_5555_5555;
    tx_frame = {40'hA1_B2C3_D4E5, 40'h01_0203_0405};
    rv0 = rv_count;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rv(rv0 + k + 1, 400);
      chk("rr_rx_ch", 64'(rx_ch), 64'(k % 2));
      chk("rr_rx_frame", 64'(rx_frame), 64'((k % 2) ? 40'h55_5555_5555 : 40'hAA_AAAA_AAAA));
      chk("rr_slave_rx", 64'(last_cap[k % 2]), 64'((k % 2) ? 40'hA1_B2C3_D4E5 : 40'h01_0203_0405));
      if (k > 0) chk("rr_period", 64'(last_period), 64'(169));
    end
    enable = 1'b0;
    repeat (8) @(negedge clk);
    chk("rr_busy_low", 64'(busy), 64'(0));
    chk("rr_never_both_low", 64'(both_low), 64'(0));

    // Enable dropped at bit 10 of a channel-0 frame
    rv0 = rv_count;
    enable = 1'b1;
    wait_cs_fall(20);
    repeat (43) @(negedge clk);
    enable = 1'b0;
    f0 = frames;
    wait_rv(rv0 + 1, 400);
    chk("ed_rx_ch", 64'(rx_ch), 64'(0));
    chk("ed_rx_frame", 64'(rx_frame), 64'(40'hAA_AAAA_AAAA));
    repeat (8) @(negedge clk);
    chk("ed_busy_low", 64'(busy), 64'(0));
    repeat (20) @(negedge clk);
    chk("ed_no_new_frame", 64'(frames), 64'(f0));
    enable = 1'b1;
    wait_cs_fall(20);
    chk("ed_next_channel", 64'(cs_n), 64'(2'b01));
    enable = 1'b0;
    wait_rv(rv0 + 2, 400);
    chk("ed_rx_ch1", 64'(rx_ch), 64'(1));

    // Reset at bit 20 of a channel-0 frame
    repeat (10) @(negedge clk);
    enable = 1'b1;
    wait_cs_fall(20);
    chk("rm_frame_ch0", 64'(cs_n), 64'(2'b10));
    repeat (83) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_cs_n", 64'(cs_n), 64'(2'b11));
    chk("rm_sck", 64'(sck), 64'(0));
    chk("rm_rx_frame", 64'(rx_frame), 64'(0));
    chk("rm_rx_valid", 64'(rx_valid), 64'(0));
    chk("rm_busy", 64'(busy), 64'(0));
    rv0 = rv_count;
    rst = 1'b0;
    exp_d.delete(); exp_c.delete();
    wait_cs_fall(20);
    chk("rm_restart_ch0", 64'(cs_n), 64'(2'b10));
    chk("rm_no_rv", 64'(rv_count), 64'(rv0));
    enable = 1'b0;
    wait_rv(rv0 + 1, 400);
    chk("rm_rx_ch", 64'(rx_ch), 64'(0));

    // tx_frame changes during XFER on channel 1
    repeat (10) @(negedge clk);
    tx_frame = {40'h0F_0E0D_0C0B, 40'h11_2233_4455};
    rv0 = rv_count;
    enable = 1'b1;
    wait_cs_fall(20);
    chk("tc_frame_ch1", 64'(cs_n), 64'(2'b01));
    repeat (60) @(negedge clk);
    tx_frame = {80{1'b1}};
    wait_rv(rv0 + 1, 400);
    chk("tc_old_value_sent", 64'(last_cap[1]), 64'(40'h0F_0E0D_0C0B));
    wait_rv(rv0 + 2, 400);
    chk("tc_new_value_ch0", 64'(last_cap[0]), 64'(40'hFF_FFFF_FFFF));
    wait_rv(rv0 + 3, 400);
    chk("tc_new_value_ch1", 64'(last_cap[1]), 64'(40'hFF_FFFF_FFFF));
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("end_never_both_low", 64'(both_low), 64'(0));
    chk("end_no_stray_sck", 64'(stray), 64'(0));
    chk("end_rv_single_cycle", 64'(wide_rv), 64'(0));
    chk("end_sb_empty", 64'(exp_d.size()), 64'(0));

    // CPOL=1, one channel, 8-bit frame
    rst1 = 1'b0;
    en1 = 1'b1;
    n = 0;
    while (rv1_count < 1 && n < 200) begin @(negedge clk); n++; end
    chk("c1_rv_seen", 64'(rv1_count), 64'(1));
    en1 = 1'b0;
    repeat (8) @(negedge clk);
    chk("c1_slave_rx", 64'(last_cap1), 64'(8'hC5));
    chk("c1_rx_frame", 64'(rxf1), 64'(8'h3C));
    chk("c1_rx_ch", 64'(rxch1), 64'(0));
    chk("c1_falls", 64'(lead1), 64'(8));
    chk("c1_rises", 64'(trail1), 64'(8));
    chk("c1_fall_first", 64'(first_fall1), 64'(1));
    chk("c1_sck_idle", 64'(sck1), 64'(1));
    chk("c1_cs_low_len", 64'(low_len1), 64'(37));
    chk("c1_busy_low", 64'(busy1), 64'(0));
    chk("c1_no_stray_sck", 64'(stray1), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
